mod_data_mem_bridge: RTL and testbench
======================================

MOD_DATA_MEM_BRIDGE -- requirements
Module: mod_data_mem_bridge

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, BUSY cycles without ack before abort; range 1..65535.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: data_address  input  32  processor load/store byte address.
REQ-005 Port: mem_read  input  1  processor load request, level, held until stall low.
REQ-006 Port: mem_write  input  1  processor store request, level, held until stall low.
REQ-007 Port: store_data  input  32  processor store data.
REQ-008 Port: load_data  output  32  registered load result to processor.
REQ-009 Port: stall  output  1  combinational; high means processor SHALL hold PC and inputs.
REQ-010 Port: align_err  output  1  one-cycle pulse, misaligned access rejected.
REQ-011 Port: bus_req  output  1  registered external memory request.
REQ-012 Port: bus_we  output  1  registered; 1 = write transaction.
REQ-013 Port: bus_addr  output  32  registered word-aligned address.
REQ-014 Port: bus_wdata  output  32  registered write data.
REQ-015 Port: bus_rdata  input  32  external read data, valid with bus_ack.
REQ-016 Port: bus_ack  input  1  external completion strobe, one cycle.
REQ-017 Port: bus_err  output  1  one-cycle pulse on timeout abort (only with macro).

Function
REQ-018 FSM states IDLE, BUSY, DONE; single transaction in flight.
REQ-019 IDLE, mem_read|mem_write, data_address[1:0]==0: latch address/data/we into bus_* and set bus_req at next edge; go BUSY; stall=1 that cycle.
REQ-020 mem_read and mem_write both high: treated as write; load_data unchanged.
REQ-021 IDLE, request with data_address[1:0]!=0: no bus transaction, stall=0, align_err pulses next cycle, state stays IDLE.
REQ-022 BUSY: bus_req, bus_we, bus_addr, bus_wdata held stable; stall=1.
REQ-023 BUSY and bus_ack: bus_req clears at that edge; read captures bus_rdata into load_data; go DONE.
REQ-024 DONE: stall=0 for exactly one cycle so processor commits; next state IDLE unconditionally.
REQ-025 Minimum request-to-commit latency: 2 cycles stall (ack in first BUSY cycle) plus DONE cycle.
REQ-026 bus_ack outside BUSY SHALL be ignored, no state or output change.
REQ-027 No request in IDLE: stall=0, bus_req=0.
REQ-028 load_data SHALL change only on read-ack capture, timeout, or reset.

Reset
REQ-029 reset high at an edge: state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, load_data=0, align_err=0, bus_err=0, timeout counter=0.
REQ-030 Reset during BUSY aborts the transaction; bus_req low after that edge; late bus_ack ignored.
REQ-031 stall=0 while reset asserted.

Configuration
REQ-032 Macro DATA_MEM_TIMEOUT_EN defined: counter increments each BUSY cycle; reaching TIMEOUT_CYCLES without ack clears bus_req, sets load_data=0, pulses bus_err, enters DONE.
REQ-033 Macro undefined: no counter, BUSY waits indefinitely for bus_ack, bus_err tied 0.

Structure
REQ-034 Shared package mips_mem_pkg holds FSM state encoding (2-bit) and the word-alignment mask constant.
REQ-035 Timeout counter SHALL be sub-module mod_mem_timeout_counter (clear, enable, expired), instantiated only under DATA_MEM_TIMEOUT_EN.

Verification
REQ-036 Read 0x0000_0010, bus_ack after 3 BUSY cycles with rdata 0x1234_5678 -> stall high 4 cycles, load_data=0x1234_5678, DONE one cycle.
REQ-037 Write 0x0000_0020 data 0xCAFE_F00D, immediate ack -> bus_we=1, bus_addr=0x20, bus_wdata=0xCAFE_F00D, load_data unchanged.
REQ-038 Read 0x0000_0013 -> no bus_req, stall=0, align_err pulse 1 cycle.
REQ-039 Macro on, TIMEOUT_CYCLES=4, no ack -> bus_req drops after 4 BUSY cycles, bus_err pulse, load_data=0.
REQ-040 Reset asserted in 2nd BUSY cycle, ack next cycle -> bus_req=0, state IDLE, ack ignored.
REQ-041 Back-to-back reads with ack each first BUSY cycle -> each completes in 3 cycles, no lost request.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: bridge FSM state encoding and the word-alignment mask.
package mips_mem_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;
    function automatic logic word_aligned(input logic [31:0] addr);
        return (addr & WORD_ALIGN_MASK) == 32'd0;
    endfunction
endpackage

// File: rtl/mod_data_mem_bridge_if.sv
// mod_data_mem_bridge_if: external memory bus between the bridge (master) and memory (slave).
interface mod_data_mem_bridge_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;
    modport master (output bus_req, bus_we, bus_addr, bus_wdata, bus_err, input bus_rdata, bus_ack);
    modport slave (input bus_req, bus_we, bus_addr, bus_wdata, bus_err, output bus_rdata, bus_ack);
endinterface

// File: rtl/mod_mem_timeout_counter.sv
// mod_mem_timeout_counter: counts enabled cycles; expired flags the LIMIT-th one.
module mod_mem_timeout_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [15:0] count;
    assign expired = enable && (count == 16'(LIMIT - 1));
    always_ff @(posedge clk) begin
        if (reset || clear) count <= 16'd0;
        else if (enable && !expired) count <= count + 16'd1;
    end
endmodule

// File: rtl/mod_data_mem_bridge.sv
// mod_data_mem_bridge: processor load/store to single-outstanding external bus bridge.
// Optional BUSY timeout abort enabled by defining DATA_MEM_TIMEOUT_EN.
module mod_data_mem_bridge
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_address,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        align_err,
    mod_data_mem_bridge_if.master bus
);
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end
    state_t state, state_next;
    logic   req, aligned, timeout;
    assign req     = mem_read | mem_write;
    assign aligned = word_aligned(data_address);
`ifdef DATA_MEM_TIMEOUT_EN
    logic err_q;
    mod_mem_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != BUSY),
        .enable  (state == BUSY),
        .expired (timeout)
    );
    // Ack in the expiring cycle wins over the abort.
    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else err_q <= (state == BUSY) && timeout && !bus.bus_ack;
    end
    assign bus.bus_err = err_q;
`else
    assign timeout     = 1'b0;
    assign bus.bus_err = 1'b0;
`endif
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                stall      = req && aligned;
                state_next = (req && aligned) ? BUSY : IDLE;
            end
            BUSY: begin
                stall      = 1'b1;
                state_next = (bus.bus_ack || timeout) ? DONE : BUSY;
            end
            default: state_next = IDLE;
        endcase
        if (reset) stall = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            align_err     <= 1'b0;
            load_data     <= 32'd0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'd0;
            bus.bus_wdata <= 32'd0;
        end else begin
            state     <= state_next;
            align_err <= (state == IDLE) && req && !aligned;
            if (state == IDLE && req && aligned) begin
                bus.bus_req   <= 1'b1;
                bus.bus_we    <= mem_write;
                bus.bus_addr  <= data_address & ~WORD_ALIGN_MASK;
                bus.bus_wdata <= store_data;
            end else if (state == BUSY && bus.bus_ack) begin
                bus.bus_req <= 1'b0;
                if (!bus.bus_we) load_data <= bus.bus_rdata;
            end else if (state == BUSY && timeout) begin
                bus.bus_req <= 1'b0;
                load_data   <= 32'd0;
            end
        end
    end
endmodule

// File: tb/tb_mod_data_mem_bridge.sv
// tb_mod_data_mem_bridge: directed stimulus with a queue-based scoreboard for the data memory bridge.
module tb_mod_data_mem_bridge;
    localparam int K_BUS = 0, K_COMMIT = 1, K_ALIGN = 2;
    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        int          n;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_address = 32'd0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] store_data = 32'd0;
    logic [31:0] load_data;
    logic        stall;
    logic        align_err;
    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          stall_run = 0;
    logic        prev_req = 1'b0;
    mod_data_mem_bridge_if bus ();
    mod_data_mem_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_address (data_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .store_data   (store_data),
        .load_data    (load_data),
        .stall        (stall),
        .align_err    (align_err),
        .bus          (bus.master)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask
    task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input int n);
        exp_t e;
        e.kind = kind; e.a = a; e.b = b; e.c = c; e.n = n;
        q.push_back(e);
    endtask
    task automatic observe(input int kind, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input int n);
        exp_t e;
        if (q.size() == 0) begin
            check("unexpected_event_kind", 32'(kind), 32'hFFFF_FFFF);
            return;
        end
        e = q.pop_front();
        check("event_kind", 32'(kind), 32'(e.kind));
        if (kind != e.kind) return;
        case (kind)
            K_BUS: begin
                check("bus_we", a, e.a);
                check("bus_addr", b, e.b);
                check("bus_wdata", c, e.c);
            end
            K_COMMIT: begin
                check("commit_load_data", a, e.a);
                check("commit_bus_err", b, e.b);
                check("commit_stall_cycles", 32'(n), 32'(e.n));
            end
            default: ;
        endcase
    endtask
    always @(negedge clk) begin
        if (reset) begin
            stall_run = 0;
            prev_req  = 1'b0;
        end else begin
            if (bus.bus_req && !prev_req) observe(K_BUS, {31'd0, bus.bus_we}, bus.bus_addr, bus.bus_wdata, 0);
            if (align_err) observe(K_ALIGN, 32'd0, 32'd0, 32'd0, 0);
            if ((mem_read || mem_write) && !stall) begin
                observe(K_COMMIT, load_data, {31'd0, bus.bus_err}, 32'd0, stall_run);
                stall_run = 0;
            end
            if (stall) stall_run++;
            prev_req = bus.bus_req;
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tick();
    endtask
    // Request is presented in IDLE; ack (if any) is raised in the n-th BUSY cycle.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input int n, input bit ack, input logic [31:0] rdat);
        mem_read     = rd;
        mem_write    = wr;
        data_address = a;
        store_data   = d;
        repeat (n) tick();
        if (ack) begin
            bus.bus_ack   = 1'b1;
            bus.bus_rdata = rdat;
        end
        tick();
        bus.bus_ack = 1'b0;
        tick();
    endtask
    initial begin
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = 32'd0;
        mem_read      = 1'b1;
        data_address  = 32'h10;
        tick();
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_bus_req", {31'd0, bus.bus_req}, 32'd0);
        check("reset_bus_we", {31'd0, bus.bus_we}, 32'd0);
        check("reset_bus_addr", bus.bus_addr, 32'd0);
        check("reset_bus_wdata", bus.bus_wdata, 32'd0);
        check("reset_load_data", load_data, 32'd0);
        check("reset_align_err", {31'd0, align_err}, 32'd0);
        check("reset_bus_err", {31'd0, bus.bus_err}, 32'd0);
        mem_read = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        push(K_BUS, 32'd0, 32'h10, 32'hDEAD_BEEF, 0);
        push(K_COMMIT, 32'h1234_5678, 32'd0, 32'd0, 4);
        access(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 3, 1'b1, 32'h1234_5678);
        idle();
        push(K_BUS, 32'd1, 32'h20, 32'hCAFE_F00D, 0);
        push(K_COMMIT, 32'h1234_5678, 32'd0, 32'd0, 2);
        access(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 1, 1'b1, 32'hFFFF_FFFF);
        idle();
        push(K_COMMIT, 32'h1234_5678, 32'd0, 32'd0, 0);
        push(K_ALIGN, 32'd0, 32'd0, 32'd0, 0);
        mem_read     = 1'b1;
        data_address = 32'h13;
        tick();
        idle();
        idle();
        push(K_BUS, 32'd1, 32'h24, 32'h0BAD_C0DE, 0);
        push(K_COMMIT, 32'h1234_5678, 32'd0, 32'd0, 2);
        access(1'b1, 1'b1, 32'h24, 32'h0BAD_C0DE, 1, 1'b1, 32'h5555_5555);
        idle();
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = 32'hAAAA_AAAA;
        tick();
        tick();
        bus.bus_ack = 1'b0;
        check("stray_ack_bus_req", {31'd0, bus.bus_req}, 32'd0);
        check("stray_ack_load_data", load_data, 32'h1234_5678);
        store_data = 32'h0;
        push(K_BUS, 32'd0, 32'h100, 32'h0, 0);
        push(K_COMMIT, 32'h1111_1111, 32'd0, 32'd0, 2);
        push(K_BUS, 32'd0, 32'h104, 32'h0, 0);
        push(K_COMMIT, 32'h2222_2222, 32'd0, 32'd0, 2);
        push(K_BUS, 32'd0, 32'h108, 32'h0, 0);
        push(K_COMMIT, 32'h3333_3333, 32'd0, 32'd0, 2);
        access(1'b1, 1'b0, 32'h100, 32'h0, 1, 1'b1, 32'h1111_1111);
        access(1'b1, 1'b0, 32'h104, 32'h0, 1, 1'b1, 32'h2222_2222);
        access(1'b1, 1'b0, 32'h108, 32'h0, 1, 1'b1, 32'h3333_3333);
        idle();
        push(K_COMMIT, 32'h3333_3333, 32'd0, 32'd0, 0);
        push(K_ALIGN, 32'd0, 32'd0, 32'd0, 0);
        mem_write    = 1'b1;
        data_address = 32'h42;
        tick();
        idle();
        idle();
`ifdef DATA_MEM_TIMEOUT_EN
        push(K_BUS, 32'd0, 32'h200, 32'h5A5A_5A5A, 0);
        push(K_COMMIT, 32'd0, 32'd1, 32'd0, 5);
        access(1'b1, 1'b0, 32'h200, 32'h5A5A_5A5A, 4, 1'b0, 32'd0);
        idle();
        check("timeout_load_data", load_data, 32'd0);
        check("timeout_bus_req", {31'd0, bus.bus_req}, 32'd0);
`endif
        push(K_BUS, 32'd0, 32'h300, 32'h0, 0);
        mem_read     = 1'b1;
        data_address = 32'h300;
        tick();
        tick();
        reset    = 1'b1;
        mem_read = 1'b0;
        tick();
        check("abort_bus_req", {31'd0, bus.bus_req}, 32'd0);
        check("abort_stall", {31'd0, stall}, 32'd0);
        reset         = 1'b0;
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = 32'h7777_7777;
        tick();
        bus.bus_ack = 1'b0;
        check("late_ack_load_data", load_data, 32'd0);
        check("late_ack_bus_req", {31'd0, bus.bus_req}, 32'd0);
        check("late_ack_stall", {31'd0, stall}, 32'd0);
        tick();
        check("late_ack_idle_stall", {31'd0, stall}, 32'd0);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("missing_event_kind", 32'hFFFF_FFFF, 32'(e.kind));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
